// File: rtl/tpu_pkg.sv
// Shared types for the TPU command queue: default widths, the queued command triple and issue FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package tpu_pkg;

    localparam int DEF_ACLEN      = 8;
    localparam int DEF_DATA_WIDTH = 32;

    // One queued command as written by the CPU.
    typedef struct packed {
        logic [DEF_ACLEN-1:0]      cmd;
        logic [DEF_DATA_WIDTH-1:0] param_1;
        logic [DEF_DATA_WIDTH-1:0] param_2;
    } tpu_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        WAIT
    } issue_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count and drop strobe.
// Latency: a pushed word is visible on pop_dat_o the cycle after the push.
// Backpressure: push while full is accepted only with a same-cycle pop, else dropped (drop_o); pop while empty is ignored.
//
// Ports: clk_i/rst_i (sync active-high), push_i/push_dat_i write side, pop_i/pop_dat_o read side,
//        full_o/empty_o/count_o status, drop_o pulses when a push is refused.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic           pop_ok;
    logic           push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;

    // When full, a simultaneous pop frees the slot being written (wr_ptr == rd_ptr),
    // and the head is read combinationally before the write lands.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && !push_ok;

    // Empty FIFO presents zero rather than stale storage.
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: every read is qualified by count.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tpu_cmd_queue.sv
// Queues CPU command triples and issues them to the TPU one at a time; buffers TPU result words for CPU reads.
// Latency: push into empty queue with TPU idle -> tpu_cmd_valid_o at +2 cycles; result visible the cycle after its strobe.
// Backpressure: full command/result FIFOs drop new words and set sticky ovf_o bits; issue waits for tpu_busy_i low.
//
// Ports: clk_i/rst_i; cmd_push_i + cmd_i/param_1_i/param_2_i enqueue; cmd_full_o/cmd_count_o status;
//        tpu_cmd_valid_o + tpu_cmd_o/tpu_param_*_o issue; tpu_busy_i; tpu_ret_valid_i/tpu_ret_data_i results in;
//        ret_pop_i/ret_valid_o/ret_data_o results out; busy_o; ovf_o/ovf_clr_i sticky overflow.
//        ACLEN/DATA_WIDTH must match the tpu_pkg defaults, which size tpu_cmd_t.
module tpu_cmd_queue
    import tpu_pkg::*;
#(
    parameter int ACLEN      = DEF_ACLEN,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CMD_DEPTH  = 8,
    parameter int RET_DEPTH  = 4,
    parameter int ISSUE_GAP  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cmd_push_i,
    input  logic [ACLEN-1:0]              cmd_i,
    input  logic [DATA_WIDTH-1:0]         param_1_i,
    input  logic [DATA_WIDTH-1:0]         param_2_i,
    output logic                          cmd_full_o,
    output logic [$clog2(CMD_DEPTH):0]    cmd_count_o,
    output logic                          tpu_cmd_valid_o,
    output logic [ACLEN-1:0]              tpu_cmd_o,
    output logic [DATA_WIDTH-1:0]         tpu_param_1_o,
    output logic [DATA_WIDTH-1:0]         tpu_param_2_o,
    input  logic                          tpu_busy_i,
    input  logic                          tpu_ret_valid_i,
    input  logic [DATA_WIDTH-1:0]         tpu_ret_data_i,
    input  logic                          ret_pop_i,
    output logic                          ret_valid_o,
    output logic [DATA_WIDTH-1:0]         ret_data_o,
    output logic                          busy_o,
    output logic [1:0]                    ovf_o,
    input  logic                          ovf_clr_i
);

    tpu_cmd_t     cmd_wr;
    tpu_cmd_t     cmd_rd;
    logic         cmd_pop;
    logic         cmd_empty;
    logic         cmd_drop;

    logic         ret_empty;
    logic         ret_full;
    logic         ret_drop;
    logic [$clog2(RET_DEPTH):0] ret_count;
    logic         unused_ret;

    issue_state_e state_q, state_d;
    logic [3:0]   gap_q, gap_d;
    tpu_cmd_t     out_q, out_d;
    logic [1:0]   ovf_q, ovf_d;

    assign cmd_wr.cmd     = cmd_i;
    assign cmd_wr.param_1 = param_1_i;
    assign cmd_wr.param_2 = param_2_i;

    sync_fifo #(
        .WIDTH ($bits(tpu_cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (cmd_push_i),
        .push_dat_i (cmd_wr),
        .pop_i      (cmd_pop),
        .pop_dat_o  (cmd_rd),
        .full_o     (cmd_full_o),
        .empty_o    (cmd_empty),
        .count_o    (cmd_count_o),
        .drop_o     (cmd_drop)
    );

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RET_DEPTH)
    ) u_ret_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (tpu_ret_valid_i),
        .push_dat_i (tpu_ret_data_i),
        .pop_i      (ret_pop_i),
        .pop_dat_o  (ret_data_o),
        .full_o     (ret_full),
        .empty_o    (ret_empty),
        .count_o    (ret_count),
        .drop_o     (ret_drop)
    );

    assign ret_valid_o = !ret_empty;
    // Result FIFO occupancy is not exported; only emptiness matters to the front-end.
    assign unused_ret  = ret_full ^ (^ret_count);

    // Issue sequencer. GAP ignores tpu_busy_i so the TPU has time to raise busy
    // after the pulse before WAIT starts trusting it.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        out_d   = out_q;
        cmd_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!cmd_empty && !tpu_busy_i) begin
                    cmd_pop = 1'b1;
                    out_d   = cmd_rd;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                gap_d   = 4'(ISSUE_GAP - 1);
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = WAIT;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            WAIT: begin
                if (!tpu_busy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Set has priority over clear so an overflow in the clear cycle is not lost.
    always_comb begin
        ovf_d = ovf_clr_i ? 2'b00 : ovf_q;
        if (cmd_drop) ovf_d[0] = 1'b1;
        if (ret_drop) ovf_d[1] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gap_q   <= '0;
            out_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tpu_cmd_valid_o = (state_q == ISSUE);
    assign tpu_cmd_o       = out_q.cmd;
    assign tpu_param_1_o   = out_q.param_1;
    assign tpu_param_2_o   = out_q.param_2;
    assign ovf_o           = ovf_q;
    assign busy_o          = !cmd_empty || (state_q != IDLE) || tpu_busy_i;

endmodule

// File: tb/tb_tpu_cmd_queue.sv
module tb_tpu_cmd_queue;
    import tpu_pkg::*;

    localparam int CD  = 8;
    localparam int RD  = 4;
    localparam int GAP_CYC = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_push_i = 1'b0;
    logic [7:0]  cmd_i = '0;
    logic [31:0] param_1_i = '0;
    logic [31:0] param_2_i = '0;
    logic        cmd_full_o;
    logic [3:0]  cmd_count_o;
    logic        tpu_cmd_valid_o;
    logic [7:0]  tpu_cmd_o;
    logic [31:0] tpu_param_1_o;
    logic [31:0] tpu_param_2_o;
    logic        tpu_busy_i = 1'b0;
    logic        tpu_ret_valid_i = 1'b0;
    logic [31:0] tpu_ret_data_i = '0;
    logic        ret_pop_i = 1'b0;
    logic        ret_valid_o;
    logic [31:0] ret_data_o;
    logic        busy_o;
    logic [1:0]  ovf_o;
    logic        ovf_clr_i = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model state
    tpu_cmd_t    mq[$];
    logic [31:0] rq[$];
    tpu_cmd_t    m_out = '0;
    logic [1:0]  m_ovf = '0;
    bit          m_ready = 1'b1;
    int          m_issue_cyc = -100;
    int          cyc = 0;

    tpu_cmd_queue #(
        .ACLEN(8), .DATA_WIDTH(32), .CMD_DEPTH(CD), .RET_DEPTH(RD), .ISSUE_GAP(GAP_CYC)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_push_i(cmd_push_i), .cmd_i(cmd_i), .param_1_i(param_1_i), .param_2_i(param_2_i),
        .cmd_full_o(cmd_full_o), .cmd_count_o(cmd_count_o),
        .tpu_cmd_valid_o(tpu_cmd_valid_o), .tpu_cmd_o(tpu_cmd_o),
        .tpu_param_1_o(tpu_param_1_o), .tpu_param_2_o(tpu_param_2_o),
        .tpu_busy_i(tpu_busy_i),
        .tpu_ret_valid_i(tpu_ret_valid_i), .tpu_ret_data_i(tpu_ret_data_i),
        .ret_pop_i(ret_pop_i), .ret_valid_o(ret_valid_o), .ret_data_o(ret_data_o),
        .busy_o(busy_o), .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; the model consumes the inputs that were present at the edge.
    // Model rules: a command leaves the queue when the sequencer is ready and the TPU is idle,
    // pulsing the next cycle; the sequencer becomes ready again once the TPU reports idle,
    // no sooner than 1+GAP cycles after the pulse.
    task automatic step();
        tpu_cmd_t t;
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            mq.delete(); rq.delete();
            m_out = '0; m_ovf = '0; m_ready = 1'b1; m_issue_cyc = -100;
        end else begin
            if (m_ready) begin
                if (mq.size() > 0 && !tpu_busy_i) begin
                    m_out = mq.pop_front();
                    m_ready = 1'b0;
                    m_issue_cyc = cyc + 1;
                end
            end else if (cyc >= m_issue_cyc + 1 + GAP_CYC && !tpu_busy_i) begin
                m_ready = 1'b1;
            end
            if (ovf_clr_i) m_ovf = 2'b00;
            if (cmd_push_i) begin
                t.cmd = cmd_i; t.param_1 = param_1_i; t.param_2 = param_2_i;
                if (mq.size() < CD) mq.push_back(t); else m_ovf[0] = 1'b1;
            end
            if (ret_pop_i && rq.size() > 0) void'(rq.pop_front());
            if (tpu_ret_valid_i) begin
                if (rq.size() < RD) rq.push_back(tpu_ret_data_i); else m_ovf[1] = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic set_cmd(input logic [7:0] c, input logic [31:0] p1, input logic [31:0] p2);
        cmd_push_i = 1'b1; cmd_i = c; param_1_i = p1; param_2_i = p2;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
        total++; if (tpu_cmd_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", tpu_cmd_valid_o); end
        total++; if (tpu_cmd_o !== 8'h00 || tpu_param_1_o !== 32'h0 || tpu_param_2_o !== 32'h0) begin bad++; $display("FAIL reset_issue_regs got=%0h/%0h/%0h exp=0/0/0", tpu_cmd_o, tpu_param_1_o, tpu_param_2_o); end
        total++; if (cmd_count_o !== 4'd0 || cmd_full_o !== 1'b0) begin bad++; $display("FAIL reset_cmd_fifo got count=%0d full=%0b exp 0/0", cmd_count_o, cmd_full_o); end
        total++; if (ret_valid_o !== 1'b0 || ret_data_o !== 32'h0) begin bad++; $display("FAIL reset_ret got=%0b/%0h exp=0/0", ret_valid_o, ret_data_o); end
        total++; if (ovf_o !== 2'b00) begin bad++; $display("FAIL reset_ovf got=%0b exp=00", ovf_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
    endtask

    task automatic test_single_issue();
        set_cmd(8'h01, 32'h10, 32'h20);
        step();
        cmd_push_i = 1'b0;
        total++; if (cmd_count_o !== 4'd1 || tpu_cmd_valid_o !== 1'b0) begin bad++; $display("FAIL single_c1 got count=%0d valid=%0b exp 1/0", cmd_count_o, tpu_cmd_valid_o); end
        step();
        total++; if (tpu_cmd_valid_o !== 1'b1) begin bad++; $display("FAIL single_pulse got=%0b exp=1", tpu_cmd_valid_o); end
        total++; if (tpu_cmd_o !== 8'h01 || tpu_param_1_o !== 32'h10 || tpu_param_2_o !== 32'h20) begin bad++; $display("FAIL single_triple got=%0h/%0h/%0h exp=1/10/20", tpu_cmd_o, tpu_param_1_o, tpu_param_2_o); end
        total++; if (cmd_count_o !== 4'd0) begin bad++; $display("FAIL single_count got=%0d exp=0", cmd_count_o); end
        step();
        total++; if (tpu_cmd_valid_o !== 1'b0 || tpu_cmd_o !== 8'h01) begin bad++; $display("FAIL single_after got valid=%0b cmd=%0h exp 0/1", tpu_cmd_valid_o, tpu_cmd_o); end
        for (int i = 0; i < 20 && busy_o; i++) step();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_idle got busy=%0b exp=0", busy_o); end
    endtask

    task automatic test_back_to_back();
        tpu_cmd_t exp_q[$];
        tpu_cmd_t t;
        int busy_left = 0;
        int last_busy = -1000;
        int pulses = 0;
        for (int i = 0; i < 60; i++) begin
            if (i < 3) begin
                t.cmd = 8'($urandom); t.param_1 = $urandom; t.param_2 = $urandom;
                set_cmd(t.cmd, t.param_1, t.param_2);
                exp_q.push_back(t);
            end else cmd_push_i = 1'b0;
            tpu_busy_i = (busy_left > 0);
            if (busy_left > 0) begin busy_left--; last_busy = cyc; end
            step();
            total++; if (tpu_cmd_valid_o !== (m_issue_cyc == cyc)) begin bad++; $display("FAIL b2b_valid cyc=%0d got=%0b exp=%0b", cyc, tpu_cmd_valid_o, m_issue_cyc == cyc); end
            total++; if (busy_o !== (mq.size() > 0 || !m_ready || tpu_busy_i)) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%0b", cyc, busy_o); end
            if (tpu_cmd_valid_o) begin
                pulses++;
                t = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total++; if ({tpu_cmd_o, tpu_param_1_o, tpu_param_2_o} !== t) begin bad++; $display("FAIL b2b_order got=%0h/%0h/%0h exp=%0h/%0h/%0h", tpu_cmd_o, tpu_param_1_o, tpu_param_2_o, t.cmd, t.param_1, t.param_2); end
                total++; if (cyc < last_busy + 3) begin bad++; $display("FAIL b2b_spacing pulse=%0d last_busy=%0d need>=%0d", cyc, last_busy, last_busy + 3); end
                busy_left = 10;
            end
        end
        tpu_busy_i = 1'b0;
        total++; if (pulses !== 3) begin bad++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL b2b_end_busy got=%0b exp=0", busy_o); end
    endtask

    task automatic test_cmd_overflow();
        tpu_cmd_t exp_q[$];
        tpu_cmd_t t;
        int busy_left = 0;
        int pulses = 0;
        tpu_busy_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            t.cmd = 8'($urandom); t.param_1 = $urandom; t.param_2 = $urandom;
            set_cmd(t.cmd, t.param_1, t.param_2);
            if (i < 8) exp_q.push_back(t);
            step();
        end
        cmd_push_i = 1'b0;
        total++; if (cmd_count_o !== 4'd8 || cmd_full_o !== 1'b1) begin bad++; $display("FAIL ovf_full got count=%0d full=%0b exp 8/1", cmd_count_o, cmd_full_o); end
        total++; if (ovf_o !== 2'b01) begin bad++; $display("FAIL ovf_cmd_flag got=%0b exp=01", ovf_o); end
        ovf_clr_i = 1'b1; step(); ovf_clr_i = 1'b0;
        total++; if (ovf_o !== 2'b00) begin bad++; $display("FAIL ovf_clear got=%0b exp=00", ovf_o); end
        for (int i = 0; i < 200 && pulses < 8; i++) begin
            tpu_busy_i = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            step();
            if (tpu_cmd_valid_o) begin
                pulses++;
                t = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total++; if ({tpu_cmd_o, tpu_param_1_o, tpu_param_2_o} !== t) begin bad++; $display("FAIL ovf_order n=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", pulses, tpu_cmd_o, tpu_param_1_o, tpu_param_2_o, t.cmd, t.param_1, t.param_2); end
                busy_left = 3;
            end
        end
        tpu_busy_i = 1'b0;
        total++; if (pulses !== 8 || cmd_count_o !== 4'd0) begin bad++; $display("FAIL ovf_drain got pulses=%0d count=%0d exp 8/0", pulses, cmd_count_o); end
        for (int i = 0; i < 20 && busy_o; i++) step();
    endtask

    task automatic test_result_fifo();
        for (int i = 0; i < 5; i++) begin
            tpu_ret_valid_i = 1'b1; tpu_ret_data_i = 32'hA0 + i;
            step();
        end
        tpu_ret_valid_i = 1'b0;
        total++; if (ret_valid_o !== 1'b1 || ret_data_o !== 32'hA0) begin bad++; $display("FAIL ret_head got=%0b/%0h exp=1/a0", ret_valid_o, ret_data_o); end
        total++; if (ovf_o !== 2'b10) begin bad++; $display("FAIL ret_ovf got=%0b exp=10", ovf_o); end
        for (int i = 0; i < 4; i++) begin
            total++; if (ret_data_o !== 32'hA0 + i) begin bad++; $display("FAIL ret_pop%0d got=%0h exp=%0h", i, ret_data_o, 32'hA0 + i); end
            ret_pop_i = 1'b1; step(); ret_pop_i = 1'b0;
        end
        total++; if (ret_valid_o !== 1'b0) begin bad++; $display("FAIL ret_empty got=%0b exp=0", ret_valid_o); end
        ret_pop_i = 1'b1; step(); ret_pop_i = 1'b0;
        total++; if (ret_valid_o !== 1'b0) begin bad++; $display("FAIL ret_underflow got=%0b exp=0", ret_valid_o); end
        // Clear-and-set in the same cycle: the set must survive.
        for (int i = 0; i < 4; i++) begin
            tpu_ret_valid_i = 1'b1; tpu_ret_data_i = 32'hC0 + i; step();
        end
        ovf_clr_i = 1'b1; tpu_ret_data_i = 32'hEE; step(); ovf_clr_i = 1'b0;
        total++; if (ovf_o !== 2'b10) begin bad++; $display("FAIL ovf_set_wins got=%0b exp=10", ovf_o); end
        ovf_clr_i = 1'b1; tpu_ret_valid_i = 1'b0; step(); ovf_clr_i = 1'b0;
        // Full with simultaneous push and pop.
        tpu_ret_valid_i = 1'b1; tpu_ret_data_i = 32'hC4; ret_pop_i = 1'b1; step();
        tpu_ret_valid_i = 1'b0; ret_pop_i = 1'b0;
        total++; if (ovf_o !== 2'b00) begin bad++; $display("FAIL ret_pushpop_ovf got=%0b exp=00", ovf_o); end
        for (int i = 1; i < 5; i++) begin
            total++; if (ret_valid_o !== 1'b1 || ret_data_o !== 32'hC0 + i) begin bad++; $display("FAIL ret_pushpop%0d got=%0b/%0h exp=1/%0h", i, ret_valid_o, ret_data_o, 32'hC0 + i); end
            ret_pop_i = 1'b1; step(); ret_pop_i = 1'b0;
        end
        total++; if (ret_valid_o !== 1'b0) begin bad++; $display("FAIL ret_pushpop_empty got=%0b exp=0", ret_valid_o); end
    endtask

    task automatic test_reset_mid();
        set_cmd(8'h31, 32'h1, 32'h2); step();
        set_cmd(8'h32, 32'h3, 32'h4); step();
        set_cmd(8'h33, 32'h5, 32'h6);
        total++; if (tpu_cmd_valid_o !== 1'b1 || tpu_cmd_o !== 8'h31) begin bad++; $display("FAIL rstmid_pulse got=%0b/%0h exp=1/31", tpu_cmd_valid_o, tpu_cmd_o); end
        step();
        cmd_push_i = 1'b0;
        total++; if (cmd_count_o !== 4'd2 || tpu_cmd_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_gap got count=%0d valid=%0b exp 2/0", cmd_count_o, tpu_cmd_valid_o); end
        rst_i = 1'b1; step(); rst_i = 1'b0;
        total++; if (cmd_count_o !== 4'd0 || cmd_full_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_state got count=%0d full=%0b busy=%0b exp 0/0/0", cmd_count_o, cmd_full_o, busy_o); end
        total++; if (tpu_cmd_o !== 8'h0 || tpu_param_1_o !== 32'h0 || tpu_param_2_o !== 32'h0 || tpu_cmd_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_regs got=%0h/%0h/%0h", tpu_cmd_o, tpu_param_1_o, tpu_param_2_o); end
        for (int i = 0; i < 20; i++) begin
            step();
            total++; if (tpu_cmd_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_reissue cyc=%0d got=1 exp=0", cyc); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            cmd_push_i = ($urandom_range(0, 2) == 0);
            cmd_i = 8'($urandom); param_1_i = $urandom; param_2_i = $urandom;
            if ($urandom_range(0, 3) == 0) tpu_busy_i = ~tpu_busy_i;
            tpu_ret_valid_i = ($urandom_range(0, 2) == 0);
            tpu_ret_data_i = $urandom;
            ret_pop_i = ($urandom_range(0, 2) == 0);
            ovf_clr_i = ($urandom_range(0, 19) == 0);
            rst_i = ($urandom_range(0, 299) == 0);
            step();
            total++; if (tpu_cmd_valid_o !== (m_issue_cyc == cyc)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b", cyc, tpu_cmd_valid_o); end
            total++; if ({tpu_cmd_o, tpu_param_1_o, tpu_param_2_o} !== m_out) begin bad++; $display("FAIL rnd_issue cyc=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", cyc, tpu_cmd_o, tpu_param_1_o, tpu_param_2_o, m_out.cmd, m_out.param_1, m_out.param_2); end
            total++; if (cmd_count_o !== 4'(mq.size()) || cmd_full_o !== (mq.size() == CD)) begin bad++; $display("FAIL rnd_cmd_count cyc=%0d got=%0d/%0b exp=%0d", cyc, cmd_count_o, cmd_full_o, mq.size()); end
            total++; if (ret_valid_o !== (rq.size() > 0)) begin bad++; $display("FAIL rnd_ret_valid cyc=%0d got=%0b exp=%0b", cyc, ret_valid_o, rq.size() > 0); end
            else if (rq.size() > 0 && ret_data_o !== rq[0]) begin bad++; $display("FAIL rnd_ret_data cyc=%0d got=%0h exp=%0h", cyc, ret_data_o, rq[0]); end
            total++; if (ovf_o !== m_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", cyc, ovf_o, m_ovf); end
            total++; if (busy_o !== (mq.size() > 0 || !m_ready || tpu_busy_i)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%0b", cyc, busy_o); end
        end
        rst_i = 1'b0; cmd_push_i = 1'b0; tpu_ret_valid_i = 1'b0; ret_pop_i = 1'b0; ovf_clr_i = 1'b0; tpu_busy_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_back_to_back();
        test_cmd_overflow();
        test_result_fifo();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tpu_cmd_queue.md
Name: tpu_cmd_queue

Overview:
Command-buffering stage between the memory-mapped TPU front-end and the TPU core. It queues {cmd, param_1, param_2} triples written by the CPU and issues them one at a time, as single-cycle pulses, whenever the TPU reports idle. It also captures TPU result words into a small FIFO that the front-end pops on CPU reads. The CPU can therefore post several commands back-to-back without polling the busy status between them.

Parameters:
ACLEN, 8, command opcode width
DATA_WIDTH, 32, parameter and result word width
CMD_DEPTH, 8, command FIFO entries (power of 2, >=2)
RET_DEPTH, 4, result FIFO entries (power of 2, >=2)
ISSUE_GAP, 2, cycles after an issue pulse before tpu_busy_i is sampled (1..15)

Ports:
clk_i  in  1  clock, all logic on the rising edge
rst_i  in  1  synchronous, active-high reset
cmd_push_i  in  1  enqueue the triple on cmd_i/param_1_i/param_2_i
cmd_i  in  ACLEN  opcode
param_1_i  in  DATA_WIDTH  parameter 1
param_2_i  in  DATA_WIDTH  parameter 2
cmd_full_o  out  1  command FIFO full
cmd_count_o  out  $clog2(CMD_DEPTH)+1  commands queued (excludes the one in flight)
tpu_cmd_valid_o  out  1  one-cycle issue pulse to the TPU
tpu_cmd_o  out  ACLEN  issued opcode
tpu_param_1_o  out  DATA_WIDTH  issued parameter 1
tpu_param_2_o  out  DATA_WIDTH  issued parameter 2
tpu_busy_i  in  1  TPU busy (1 = busy)
tpu_ret_valid_i  in  1  TPU result strobe
tpu_ret_data_i  in  DATA_WIDTH  TPU result word
ret_pop_i  in  1  dequeue the head result
ret_valid_o  out  1  result FIFO non-empty
ret_data_o  out  DATA_WIDTH  head result (first-word fall-through)
busy_o  out  1  queue non-empty OR FSM not IDLE OR tpu_busy_i
ovf_o  out  2  sticky overflow flags: [0] command drop, [1] result drop
ovf_clr_i  in  1  clear both ovf_o bits

Behaviour:
- Reset (sync, active-high; takes effect at the next edge, including mid-operation):
  - both FIFOs emptied and the FSM returns to IDLE;
  - tpu_cmd_valid_o=0, tpu_cmd_o=0, tpu_param_*_o=0;
  - ret_valid_o=0, ret_data_o=0, ovf_o=0, cmd_full_o=0, cmd_count_o=0;
  - an in-flight command is abandoned and is not re-issued.
- Command FIFO:
  - push is accepted when count<CMD_DEPTH, or when a pop (ISSUE entry) occurs in the same cycle;
  - a push while full with no simultaneous pop is dropped and sets ovf_o[0];
  - pointers wrap modulo CMD_DEPTH.
- Issue FSM states: IDLE, ISSUE, GAP, WAIT.
  - IDLE: if the FIFO is non-empty and tpu_busy_i=0, pop the head into the output registers and go to ISSUE.
  - ISSUE: tpu_cmd_valid_o=1 for exactly this cycle; tpu_cmd_o/tpu_param_*_o hold the popped triple and keep it until the next issue. Load gap counter = ISSUE_GAP-1 and go to GAP.
  - GAP: decrement the counter; at 0 go to WAIT. tpu_busy_i is ignored in this state, to cover the TPU's busy-rise latency.
  - WAIT: if tpu_busy_i=0, go to IDLE.
  - Back-to-back issue spacing is at least 2+ISSUE_GAP cycles.
- Latency:
  - push at cycle N into an empty queue, FSM in IDLE, TPU idle -> tpu_cmd_valid_o high at N+2;
  - the push and the pop of the same entry cannot occur in the same cycle.
- Result FIFO:
  - tpu_ret_valid_i pushes tpu_ret_data_i;
  - ret_valid_o and ret_data_o are updated the cycle after the push;
  - push while full is accepted only with a simultaneous ret_pop_i; otherwise the word is dropped and ovf_o[1] is set;
  - ret_pop_i while empty is ignored (no underflow, pointers unchanged).
- ovf_o: ovf_clr_i clears the flags; if a new overflow occurs in the same cycle as a clear, the set wins.
- busy_o is combinational from registered state and tpu_busy_i.

Decomposition:
- Package tpu_pkg:
  - ACLEN and DATA_WIDTH defaults;
  - typedef struct packed tpu_cmd_t {cmd, param_1, param_2};
  - typedef enum issue_state_e {IDLE, ISSUE, GAP, WAIT}.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; first-word fall-through; push/pop/full/empty/count). Instantiated twice: as the command FIFO with WIDTH = $bits(tpu_cmd_t), and as the result FIFO.

Test Plan:
- Push cmd 0x01 (p1=0x10, p2=0x20) at cycle 0, TPU idle -> tpu_cmd_valid_o pulses at cycle 2 with 0x01/0x10/0x20; cmd_count_o returns to 0.
- Push 3 commands; TPU model holds busy 10 cycles after each issue (rising 1 cycle after the pulse) -> exactly 3 pulses, in order, each starting at least 2 cycles after busy falls; busy_o high throughout and low 1 cycle after the last busy falls.
- Push 9 commands with TPU busy held high -> 8 queued, cmd_full_o=1, ovf_o=2'b01; ovf_clr_i -> ovf_o=0; release busy -> first 8 triples issued in order.
- Fire 5 tpu_ret_valid_i words 0xA0..0xA4 with no pops -> ret_data_o=0xA0, ovf_o[1]=1; 4 pops return 0xA0..0xA3, then ret_valid_o=0; extra pop is harmless.
- Result FIFO full plus simultaneous tpu_ret_valid_i and ret_pop_i -> no overflow, count stays 4.
- Assert rst_i during GAP with 2 commands queued -> next cycle all outputs at reset values; no further issue pulses after rst_i deasserts.
